// File: rtl/lbist_pkg.sv
// Shared constants, FSM state type and mask helpers for the LBIST pattern-pair source.
package lbist_pkg;

    localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [3:0] MAX_FLIPS    = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } lbist_state_e;

    function automatic logic [3:0] clamp_flips(input logic [3:0] flips);
        return (flips > MAX_FLIPS) ? MAX_FLIPS : flips;
    endfunction

    // Run of f ones rotated left by rot; popcount is exactly f.
    function automatic logic [7:0] flip_mask(input logic [3:0] f, input logic [2:0] rot);
        logic [7:0]  base;
        logic [15:0] dbl;
        base = (f >= MAX_FLIPS) ? 8'hFF : ((8'd1 << f) - 8'd1);
        dbl  = {base, base} << rot;
        return dbl[15:8];
    endfunction

endpackage

// File: rtl/lbist_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with synchronous load and advance enable.
module lbist_lfsr8
    import lbist_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       adv_i,
    output logic [7:0] lfsr_o,
    output logic [7:0] lfsr_next_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_next_o = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    assign lfsr_o      = lfsr_q;

    // Load has priority over advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (adv_i) begin
            lfsr_d = lfsr_next_o;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/lbist_err_inject.sv
// Golden/corrupted pattern-pair source over valid/ready for the Hamming-distance checker.
// Build option LBIST_INJ_SWEEP_EN: flip count sweeps k mod 9 per pattern, FLIPS ignored.
module lbist_err_inject
    import lbist_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] FLIPS,
    input  logic [7:0] NUM_PAT,
    input  logic       READY,
    output logic       VALID,
    output logic [7:0] SIG_IN,
    output logic [7:0] SIG_OUT,
    output logic [3:0] FLIP_CNT,
    output logic       BUSY,
    output logic       DONE
);

    lbist_state_e state_q, state_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] sig_in_q, sig_in_d;
    logic [7:0] sig_out_q, sig_out_d;
    logic [3:0] flip_cnt_q, flip_cnt_d;
    logic [3:0] f_q, f_d;
    logic [2:0] rot_q, rot_d;
    logic [8:0] rem_q, rem_d;

    logic       lfsr_load_s;
    logic       lfsr_adv_s;
    logic [7:0] lfsr_s;
    logic [7:0] lfsr_next_s;
    logic [3:0] start_f_s;
    logic [3:0] next_f_s;
    logic [2:0] next_rot_s;

    lbist_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk_i       (CLK),
        .rst_i       (RST),
        .load_i      (lfsr_load_s),
        .seed_i      (SEED),
        .adv_i       (lfsr_adv_s),
        .lfsr_o      (lfsr_s),
        .lfsr_next_o (lfsr_next_s)
    );

    // In sweep mode f_q doubles as the pattern index mod 9.
`ifdef LBIST_INJ_SWEEP_EN
    assign start_f_s = 4'd0;
    assign next_f_s  = (f_q >= MAX_FLIPS) ? 4'd0 : (f_q + 4'd1);
`else
    assign start_f_s = clamp_flips(FLIPS);
    assign next_f_s  = f_q;
`endif
    assign next_rot_s = rot_q + 3'd1;

    // Next-state and next-pair computation.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sig_in_d    = sig_in_q;
        sig_out_d   = sig_out_q;
        flip_cnt_d  = flip_cnt_q;
        f_d         = f_q;
        rot_d       = rot_q;
        rem_d       = rem_q;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (START) begin
                    f_d         = start_f_s;
                    rot_d       = 3'd0;
                    rem_d       = (NUM_PAT == 8'd0) ? 9'd256 : {1'b0, NUM_PAT};
                    lfsr_load_s = 1'b1;
                    sig_in_d    = SEED;
                    sig_out_d   = SEED ^ flip_mask(start_f_s, 3'd0);
                    flip_cnt_d  = start_f_s;
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (valid_q && READY) begin
                    if (rem_q == 9'd1) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        lfsr_adv_s = 1'b1;
                        rot_d      = next_rot_s;
                        rem_d      = rem_q - 9'd1;
                        f_d        = next_f_s;
                        sig_in_d   = lfsr_next_s;
                        sig_out_d  = lfsr_next_s ^ flip_mask(next_f_s, next_rot_s);
                        flip_cnt_d = next_f_s;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_FIN: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sig_in_q   <= 8'd0;
            sig_out_q  <= 8'd0;
            flip_cnt_q <= 4'd0;
            f_q        <= 4'd0;
            rot_q      <= 3'd0;
            rem_q      <= 9'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sig_in_q   <= sig_in_d;
            sig_out_q  <= sig_out_d;
            flip_cnt_q <= flip_cnt_d;
            f_q        <= f_d;
            rot_q      <= rot_d;
            rem_q      <= rem_d;
        end
    end

    assign VALID    = valid_q;
    assign SIG_IN   = sig_in_q;
    assign SIG_OUT  = sig_out_q;
    assign FLIP_CNT = flip_cnt_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_lbist_err_inject.sv
// Directed self-checking bench for lbist_err_inject (default build).
module tb_lbist_err_inject;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [3:0] FLIPS = 4'd0;
    logic [7:0] NUM_PAT = 8'd0;
    logic       READY = 1'b0;
    logic       VALID;
    logic [7:0] SIG_IN;
    logic [7:0] SIG_OUT;
    logic [3:0] FLIP_CNT;
    logic       BUSY;
    logic       DONE;

    int total = 0;
    int bad   = 0;

    logic [7:0] t1_in [4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
    logic [7:0] t2_in [3] = '{8'hA5, 8'h4A, 8'h95};
    logic [7:0] t2_out[3] = '{8'hA6, 8'h4C, 8'h99};

    lbist_err_inject dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .FLIPS    (FLIPS),
        .NUM_PAT  (NUM_PAT),
        .READY    (READY),
        .VALID    (VALID),
        .SIG_IN   (SIG_IN),
        .SIG_OUT  (SIG_OUT),
        .FLIP_CNT (FLIP_CNT),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR step written out bit by bit: taps 7,5,4,3.
    function automatic logic [7:0] ref_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    initial begin
        int beats;
        logic [7:0] model;

        // Reset
        step();
        step();
        chk("rst_valid", {15'd0, VALID}, 16'd0);
        chk("rst_sig_in", {8'd0, SIG_IN}, 16'd0);
        chk("rst_sig_out", {8'd0, SIG_OUT}, 16'd0);
        chk("rst_flip_cnt", {12'd0, FLIP_CNT}, 16'd0);
        chk("rst_busy", {15'd0, BUSY}, 16'd0);
        chk("rst_done", {15'd0, DONE}, 16'd0);
        RST = 1'b0;
        step();

        // Zero flips, 4 patterns, back-to-back
        FLIPS = 4'd0; NUM_PAT = 8'd4; READY = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", {15'd0, VALID}, 16'd1);
            chk("t1_sig_in", {8'd0, SIG_IN}, {8'd0, t1_in[i]});
            chk("t1_sig_out", {8'd0, SIG_OUT}, {8'd0, t1_in[i]});
            chk("t1_flip_cnt", {12'd0, FLIP_CNT}, 16'd0);
            chk("t1_done_low", {15'd0, DONE}, 16'd0);
            step();
        end
        chk("t1_valid_end", {15'd0, VALID}, 16'd0);
        chk("t1_done", {15'd0, DONE}, 16'd1);
        chk("t1_busy_fin", {15'd0, BUSY}, 16'd1);
        step();
        chk("t1_done_clear", {15'd0, DONE}, 16'd0);
        chk("t1_busy_clear", {15'd0, BUSY}, 16'd0);

        // Two flips, 3 patterns, backpressure after beat 1; late input changes ignored
        FLIPS = 4'd2; NUM_PAT = 8'd3; START = 1'b1;
        step();
        START = 1'b0; FLIPS = 4'd7; NUM_PAT = 8'd1;
        chk("t2_in0", {8'd0, SIG_IN}, {8'd0, t2_in[0]});
        chk("t2_out0", {8'd0, SIG_OUT}, {8'd0, t2_out[0]});
        chk("t2_cnt0", {12'd0, FLIP_CNT}, 16'd2);
        step();
        READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {15'd0, VALID}, 16'd1);
            chk("bp_sig_in", {8'd0, SIG_IN}, {8'd0, t2_in[1]});
            chk("bp_sig_out", {8'd0, SIG_OUT}, {8'd0, t2_out[1]});
            chk("bp_flip_cnt", {12'd0, FLIP_CNT}, 16'd2);
        end
        READY = 1'b1;
        step();
        chk("t2_in2", {8'd0, SIG_IN}, {8'd0, t2_in[2]});
        chk("t2_out2", {8'd0, SIG_OUT}, {8'd0, t2_out[2]});
        chk("t2_cnt2", {12'd0, FLIP_CNT}, 16'd2);
        step();
        chk("t2_valid_end", {15'd0, VALID}, 16'd0);
        chk("t2_done", {15'd0, DONE}, 16'd1);
        step();

        // Clamped flips, 256 patterns
        FLIPS = 4'd12; NUM_PAT = 8'd0; START = 1'b1;
        step();
        START = 1'b0;
        beats = 0;
        model = 8'hA5;
        for (int c = 0; c < 300; c++) begin
            if (!VALID) break;
            chk("t4_sig_in", {8'd0, SIG_IN}, {8'd0, model});
            chk("t4_sig_out", {8'd0, SIG_OUT}, {8'd0, ~model});
            chk("t4_flip_cnt", {12'd0, FLIP_CNT}, 16'd8);
            model = ref_next(model);
            beats++;
            step();
        end
        chk("t4_beats", beats[15:0], 16'd256);
        chk("t4_done", {15'd0, DONE}, 16'd1);
        step();
        chk("t4_done_clear", {15'd0, DONE}, 16'd0);

        // Mid-run reset; START during SEND ignored
        FLIPS = 4'd1; NUM_PAT = 8'd10; START = 1'b1;
        step();
        chk("t5_in0", {8'd0, SIG_IN}, 16'h00A5);
        chk("t5_out0", {8'd0, SIG_OUT}, 16'h00A4);
        step();
        START = 1'b0;
        chk("t5_start_ignored_in", {8'd0, SIG_IN}, 16'h004A);
        chk("t5_out1", {8'd0, SIG_OUT}, 16'h0048);
        step();
        chk("t5_out2", {8'd0, SIG_OUT}, 16'h0091);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("t5_rst_valid", {15'd0, VALID}, 16'd0);
        chk("t5_rst_busy", {15'd0, BUSY}, 16'd0);
        chk("t5_rst_sig_in", {8'd0, SIG_IN}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_done", {15'd0, DONE}, 16'd0);
        end
        FLIPS = 4'd3; NUM_PAT = 8'd1; START = 1'b1;
        step();
        START = 1'b0;
        chk("t5_restart_in", {8'd0, SIG_IN}, 16'h00A5);
        chk("t5_restart_out", {8'd0, SIG_OUT}, 16'h00A2);
        chk("t5_restart_cnt", {12'd0, FLIP_CNT}, 16'd3);
        step();
        chk("t5_single_done", {15'd0, DONE}, 16'd1);
        chk("t5_single_valid", {15'd0, VALID}, 16'd0);
        step();
        chk("t5_idle_busy", {15'd0, BUSY}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
